// File: rtl/status_pkg.sv
// Shared types and helpers for the status-LED arbiter and its tick generator.
package status_pkg;

  localparam int unsigned LED_W   = 3;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } sel_t;

  // Lowest set bit wins; the loop runs high-to-low so the last hit is the lowest index.
  function automatic sel_t lowest_set(input logic [MAX_REQ-1:0] vec);
    sel_t s;
    s = '0;
    for (int unsigned i = MAX_REQ; i > 0; i--) begin
      if (vec[i-1]) begin
        s.valid = 1'b1;
        s.idx   = 3'(i - 1);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a slow tick and an 8-bit tick counter.
module tick_gen #(
  parameter int unsigned PRESCALE_BITS = 22
) (
  input  logic       input_clk,
  input  logic       reset,
  output logic       tick,
  output logic [7:0] tick_cnt
);

  logic [PRESCALE_BITS-1:0] prescaler_q, prescaler_d;
  logic [7:0]               tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick        = &prescaler_q;
    prescaler_d = prescaler_q + PRESCALE_BITS'(1);
    tick_cnt_d  = tick ? tick_cnt_q + 8'd1 : tick_cnt_q;
  end

  always_ff @(posedge input_clk) begin
    if (reset) begin
      prescaler_q <= '0;
      tick_cnt_q  <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  assign tick_cnt = tick_cnt_q;

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority arbiter sharing three active-low status LEDs among requesters,
// with a minimum grant hold, optional blink and an idle heartbeat.
module led_status_arbiter
  import status_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned PRESCALE_BITS = 22,
  parameter int unsigned HOLD_TICKS    = 8,
  parameter int unsigned BLINK_SHIFT   = 1
) (
  input  logic                     input_clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LED_W*NUM_REQ-1:0] req_pattern,
  input  logic [NUM_REQ-1:0]       req_blink,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         leds
);

  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

  logic             tick;
  logic [7:0]       tick_cnt;
  logic             tick_cnt_unused;

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic             blink_q, blink_d;

  logic [LED_W-1:0]   pat_arr [NUM_REQ];
  logic [MAX_REQ-1:0] req_ext;
  sel_t               sel;
  logic [OW-1:0]      new_owner;
  logic               take;
  logic               hold_ok;

  tick_gen #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_tick_gen (
    .input_clk(input_clk),
    .reset    (reset),
    .tick     (tick),
    .tick_cnt (tick_cnt)
  );

  assign tick_cnt_unused = ^tick_cnt;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pat_arr[i] = req_pattern[LED_W*i +: LED_W];
    end
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    sel                  = lowest_set(req_ext);
  end

  // Preemption (a) and hand-over (b) collapse into "lowest active index differs
  // from owner": if the owner still requests, any different lowest index is higher priority.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    pattern_d = pattern_q;
    blink_d   = blink_q;
    new_owner = OW'(sel.idx);
    take      = 1'b0;
    hold_ok   = (hold_q == HW'(HOLD_TICKS));

    if (state_q == ST_IDLE) begin
      take = sel.valid;
    end else begin
      if (req[owner_q]) begin
        pattern_d = pat_arr[owner_q];
        blink_d   = req_blink[owner_q];
      end
      if (tick && !hold_ok) begin
        hold_d = hold_q + HW'(1);
      end
      if (hold_ok) begin
        if (!sel.valid) begin
          state_d = ST_IDLE;
        end else if (new_owner != owner_q) begin
          take = 1'b1;
        end
      end
    end

    if (take) begin
      state_d   = ST_SHOW;
      owner_d   = new_owner;
      hold_d    = '0;
      pattern_d = pat_arr[new_owner];
      blink_d   = req_blink[new_owner];
    end
  end

  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      hold_q    <= '0;
      pattern_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      pattern_q <= pattern_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == ST_SHOW) begin
      grant[owner_q] = 1'b1;
      leds = ~(pattern_q & {LED_W{~blink_q | tick_cnt[BLINK_SHIFT]}});
    end else begin
      leds = ~tick_cnt[7:5];
    end
  end

endmodule
